// File: rtl/uart_rom_loader.sv
// UART byte-stream to ROM loader.
// Packs received bytes little-endian into 32-bit words and writes them out.
module uart_rom_loader #(
  parameter int unsigned CLK_rate  = 100000000,
  parameter int unsigned Baud_rate = 9600,
  parameter int unsigned MAX_WORDS = 500
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_load_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        w_rom_en_o,
  output logic [15:0] w_rom_addr_o,
  output logic [31:0] w_rom_data_o,
  output logic [15:0] word_count_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);

  localparam int unsigned TIMEOUT =
    (CLK_rate / Baud_rate) * 20;
  localparam int unsigned TMR_BITS =
    $clog2(TIMEOUT + 1);
  localparam int unsigned TMR_W =
    (TMR_BITS > 21) ? TMR_BITS : 21;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'(TIMEOUT);
  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        word_q, word_d;
  logic [15:0]        word_count_q, word_count_d;
  logic               overflow_q, overflow_d;
  logic               wr_en;
  logic               rom_full;

  assign rom_full = (word_count_q >= MAX_W);

  // State register; reset drops any partial session at once.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next-state: byte packing, idle timeout, write and overflow.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en_load_i && rx_valid_i) begin
          word_count_d = '0;
          overflow_d   = 1'b0;
          word_d       = {24'b0, rx_data_i};
          byte_idx_d   = 2'd1;
          timer_d      = TMR_LOAD;
          state_d      = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (!en_load_i) begin
          word_d     = '0;
          byte_idx_d = '0;
          timer_d    = '0;
          state_d    = S_IDLE;
        end else if (rx_valid_i) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
          byte_idx_d = byte_idx_q + 2'd1;
          timer_d    = TMR_LOAD;
          if (byte_idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end else if (timer_q == '0) begin
          state_d = (byte_idx_q != 2'd0) ? S_WRITE
                                         : S_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      S_WRITE: begin
        if (!en_load_i) begin
          word_d     = '0;
          byte_idx_d = '0;
          timer_d    = '0;
          state_d    = S_IDLE;
        end else if (rom_full) begin
          overflow_d = 1'b1;
          word_d     = '0;
          byte_idx_d = '0;
          timer_d    = '0;
          state_d    = S_DONE;
        end else begin
          wr_en        = 1'b1;
          word_count_d = word_count_q + 16'd1;
          timer_d      = TMR_LOAD;
          state_d      = S_COLLECT;
          // A byte landing now starts the next word.
          if (rx_valid_i) begin
            word_d     = {24'b0, rx_data_i};
            byte_idx_d = 2'd1;
          end else begin
            word_d     = '0;
            byte_idx_d = '0;
          end
        end
      end

      S_DONE: begin
        if (!en_load_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_rom_en_o   = wr_en;
  assign w_rom_addr_o = wr_en ? word_count_q : '0;
  assign w_rom_data_o = wr_en ? word_q : '0;
  assign word_count_o = word_count_q;
  assign busy_o       = (state_q == S_COLLECT) ||
                        (state_q == S_WRITE);
  assign done_o       = (state_q == S_DONE);
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader.
// Vector table of load sessions plus hand sequences for abort/overflow.
module tb_uart_rom_loader;

  localparam int unsigned CLK  = 1000;
  localparam int unsigned BAUD = 100;
  localparam int          T    = (CLK / BAUD) * 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_load;
  logic        rx_valid;
  logic [7:0]  rx_data;

  logic        m_en, s_en;
  logic [15:0] m_addr, s_addr;
  logic [31:0] m_data, s_data;
  logic [15:0] m_cnt, s_cnt;
  logic        m_busy, s_busy;
  logic        m_done, s_done;
  logic        m_ovf, s_ovf;

  uart_rom_loader #(
    .CLK_rate(CLK), .Baud_rate(BAUD)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .en_load_i(en_load), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data),
    .w_rom_en_o(m_en), .w_rom_addr_o(m_addr),
    .w_rom_data_o(m_data), .word_count_o(m_cnt),
    .busy_o(m_busy), .done_o(m_done),
    .overflow_o(m_ovf)
  );

  uart_rom_loader #(
    .CLK_rate(CLK), .Baud_rate(BAUD),
    .MAX_WORDS(2)
  ) dut_small (
    .clk_i(clk), .rst_n_i(rst_n),
    .en_load_i(en_load), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data),
    .w_rom_en_o(s_en), .w_rom_addr_o(s_addr),
    .w_rom_data_o(s_data), .word_count_o(s_cnt),
    .busy_o(s_busy), .done_o(s_done),
    .overflow_o(s_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    int          n;
    logic [95:0] bytes;
    int          gap;
    int          nw;
    logic [95:0] words;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  sexp_q[$];
  bit   chk_small = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] a,
                      input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic spush(input logic [15:0] a,
                       input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sexp_q.push_back(e);
  endtask

  task automatic send(input int n,
                      input logic [95:0] b,
                      input int gap);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = b[8*i +: 8];
      tick();
      rx_valid = 1'b0;
      if (gap != 0 && i != n - 1) begin
        repeat (gap) tick();
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = 0;
    while (!m_done && n < 2 * T + 50) begin
      tick();
      n++;
    end
    chk("done_reached", 32'(m_done), 32'd1);
    checks++;
    if (n < exp_n - 2 || n > exp_n + 2) begin
      errors++;
      $display("FAIL done_latency: got %0d expected %0d",
               n, exp_n);
    end
  endtask

  // Scoreboard for the default-depth instance.
  always @(negedge clk) begin
    if (m_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 m_addr, m_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(m_addr), 32'(e.addr));
        chk("write_data", m_data, e.data);
      end
    end else begin
      chk("idle_addr", 32'(m_addr), 32'd0);
      chk("idle_data", m_data, 32'd0);
    end
  end

  // Scoreboard for the two-word instance.
  always @(negedge clk) begin
    if (chk_small && s_en) begin
      if (sexp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected_write: got addr %h data %h expected none",
                 s_addr, s_data);
      end else begin
        wr_t e;
        e = sexp_q.pop_front();
        chk("small_addr", 32'(s_addr), 32'(e.addr));
        chk("small_data", s_data, e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{n: 8, bytes: 96'h8877665544332211,
                gap: 2, nw: 2,
                words: {32'h0, 32'h88776655, 32'h44332211}};
    vecs[1] = '{n: 2, bytes: 96'hBBAA,
                gap: 2, nw: 1,
                words: {64'h0, 32'h0000BBAA}};
    vecs[2] = '{n: 5, bytes: 96'hB5A4A3A2A1,
                gap: 0, nw: 2,
                words: {32'h0, 32'h000000B5, 32'hA4A3A2A1}};
    vecs[3] = '{n: 5, bytes: 96'h0504030201,
                gap: 3, nw: 2,
                words: {32'h0, 32'h00000005, 32'h04030201}};
    vecs[4] = '{n: 8, bytes: 96'h8877665544332211,
                gap: 0, nw: 2,
                words: {32'h0, 32'h88776655, 32'h44332211}};

    rst_n    = 1'b0;
    en_load  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk("rst_en", 32'(m_en), 32'd0);
    chk("rst_cnt", 32'(m_cnt), 32'd0);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_ovf", 32'(m_ovf), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Bytes with loading disabled are ignored.
    send(1, 96'h5C, 0);
    tick();
    chk("ignore_busy", 32'(m_busy), 32'd0);
    chk("ignore_cnt", 32'(m_cnt), 32'd0);

    for (int v = 0; v < 5; v++) begin
      en_load = 1'b1;
      tick();
      for (int w = 0; w < vecs[v].nw; w++) begin
        push(16'(w), vecs[v].words[32*w +: 32]);
      end
      send(vecs[v].n, vecs[v].bytes, vecs[v].gap);
      wait_done((vecs[v].n % 4 == 0) ? T + 3
                                      : 2 * T + 3);
      chk("vec_cnt", 32'(m_cnt), 32'(vecs[v].nw));
      chk("vec_pending", 32'(exp_q.size()), 32'd0);
      chk("vec_busy", 32'(m_busy), 32'd0);
      chk("vec_ovf", 32'(m_ovf), 32'd0);
      send(1, 96'hEE, 0);
      tick();
      chk("done_holds", 32'(m_done), 32'd1);
      chk("done_cnt", 32'(m_cnt), 32'(vecs[v].nw));
      en_load = 1'b0;
      tick();
      tick();
      chk("idle_done", 32'(m_done), 32'd0);
      chk("idle_cnt_kept", 32'(m_cnt), 32'(vecs[v].nw));
    end

    // Two-word ROM fed twelve bytes.
    chk_small = 1'b1;
    en_load = 1'b1;
    tick();
    spush(16'd0, 32'h04030201);
    spush(16'd1, 32'h08070605);
    push(16'd0, 32'h04030201);
    push(16'd1, 32'h08070605);
    push(16'd2, 32'h0C0B0A09);
    send(12, 96'h0C0B0A090807060504030201, 2);
    tick();
    tick();
    chk("ovf_flag", 32'(s_ovf), 32'd1);
    chk("ovf_done", 32'(s_done), 32'd1);
    chk("ovf_cnt", 32'(s_cnt), 32'd2);
    chk("ovf_pending", 32'(sexp_q.size()), 32'd0);
    wait_done(T + 1);
    chk("big_cnt", 32'(m_cnt), 32'd3);
    chk("big_ovf", 32'(m_ovf), 32'd0);
    chk("big_pending", 32'(exp_q.size()), 32'd0);
    en_load = 1'b0;
    tick();
    tick();
    chk("ovf_sticky", 32'(s_ovf), 32'd1);
    chk("ovf_idle", 32'(s_done), 32'd0);
    chk_small = 1'b0;

    // Load aborted after three bytes.
    en_load = 1'b1;
    tick();
    send(3, 96'h333231, 2);
    tick();
    chk("abort_busy", 32'(m_busy), 32'd1);
    chk("ovf_cleared", 32'(s_ovf), 32'd0);
    en_load = 1'b0;
    tick();
    chk("abort_idle", 32'(m_busy), 32'd0);
    chk("abort_done", 32'(m_done), 32'd0);
    repeat (T + 10) tick();
    chk("abort_cnt", 32'(m_cnt), 32'd0);
    en_load = 1'b1;
    tick();
    push(16'd0, 32'h0000005A);
    send(1, 96'h5A, 0);
    wait_done(2 * T + 3);
    chk("restart_cnt", 32'(m_cnt), 32'd1);
    chk("restart_pending", 32'(exp_q.size()), 32'd0);
    en_load = 1'b0;
    tick();
    tick();

    // Reset in the middle of the second word.
    en_load = 1'b1;
    tick();
    push(16'd0, 32'h24232221);
    send(6, 96'h262524232221, 2);
    tick();
    chk("pre_rst_cnt", 32'(m_cnt), 32'd1);
    chk("pre_rst_busy", 32'(m_busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(m_en), 32'd0);
    chk("arst_addr", 32'(m_addr), 32'd0);
    chk("arst_data", m_data, 32'd0);
    chk("arst_cnt", 32'(m_cnt), 32'd0);
    chk("arst_busy", 32'(m_busy), 32'd0);
    chk("arst_done", 32'(m_done), 32'd0);
    chk("arst_ovf", 32'(m_ovf), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * T + 10) tick();
    chk("post_rst_busy", 32'(m_busy), 32'd0);
    chk("post_rst_done", 32'(m_done), 32'd0);
    chk("post_rst_pending", 32'(exp_q.size()), 32'd0);
    en_load = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
